// File: rtl/isl51002_sync_ctrl.sv
// Sync-lock supervisor and timing-config sequencer for the ISL51002 capture frontend.
// Latency: lock/irq outputs 1 cycle after the qualifying frame edge; config applies 1 cycle after write (unlocked) or at the next frame edge (locked).
// Backpressure: none. A write that collides with an apply defers the apply to the next opportunity; back-to-back writes coalesce.
//
// Ports:
//   PCLK_i, reset                        pixel clock, synchronous active-high reset
//   frame_change_i, vtotal_i, interlace_i frontend frame timing observation
//   cfg_wr_i, cfg_h_i, cfg_h2_i, cfg_v_i  CPU write strobe and pending timing config
//   h_in_config_o, h_in_config2_o,
//   v_in_config_o, cfg_applied_o         active config and its apply pulse
//   sync_locked_o, locked_vtotal_o,
//   locked_il_o, mode_irq_o              lock status, reference timing, lock change pulse
//   wdog_timeout_o                       sticky watchdog-unlock flag
//
// Build option: define SYNC_CTRL_WDOG_EN to include the frame-edge watchdog.
// Without it wdog_timeout_o is tied 0 and lock is only lost through missed frames.

module isl51002_sync_ctrl #(
    parameter int LOCK_FRAMES = 4,
    parameter int MISS_FRAMES = 2,
    parameter int VTOTAL_TOL  = 1,
    parameter int WDOG_CYCLES = 2097152
) (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic        frame_change_i,
    input  logic [10:0] vtotal_i,
    input  logic        interlace_i,
    input  logic        cfg_wr_i,
    input  logic [31:0] cfg_h_i,
    input  logic [31:0] cfg_h2_i,
    input  logic [31:0] cfg_v_i,
    output logic [31:0] h_in_config_o,
    output logic [31:0] h_in_config2_o,
    output logic [31:0] v_in_config_o,
    output logic        cfg_applied_o,
    output logic        sync_locked_o,
    output logic [10:0] locked_vtotal_o,
    output logic        locked_il_o,
    output logic        mode_irq_o,
    output logic        wdog_timeout_o
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Terminal counts: the edge that finds the counter at this value is the
    // one that completes the lock (or drops it).
    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 2);
    localparam logic [7:0]  MISS_LAST = 8'(MISS_FRAMES - 1);
    localparam logic [10:0] TOL       = 11'(VTOTAL_TOL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        fc_prev_q;
    logic [1:0]  state_q,       state_d;
    logic [10:0] ref_vtotal_q,  ref_vtotal_d;
    logic        ref_il_q,      ref_il_d;
    logic [7:0]  match_ctr_q,   match_ctr_d;
    logic [7:0]  miss_ctr_q,    miss_ctr_d;
    logic        sync_locked_q, sync_locked_d;
    logic        mode_irq_q,    mode_irq_d;

    logic [31:0] shadow_h_q,    shadow_h_d;
    logic [31:0] shadow_h2_q,   shadow_h2_d;
    logic [31:0] shadow_v_q,    shadow_v_d;
    logic        pending_q,     pending_d;
    logic [31:0] active_h_q,    active_h_d;
    logic [31:0] active_h2_q,   active_h2_d;
    logic [31:0] active_v_q,    active_v_d;
    logic        cfg_applied_q, cfg_applied_d;

    logic        wdog_timeout_q, wdog_timeout_d;

    logic        fc_edge;
    logic [10:0] vdiff;
    logic        match;
    logic        apply_en;
    logic        wdog_hit;

    // ------------------------------------------------------------------
    // Frame edge detect and frame match
    // ------------------------------------------------------------------
    assign fc_edge = frame_change_i & ~fc_prev_q;

    // Plain unsigned distance; no wrap so 0 and 2047 are far apart.
    assign vdiff = (vtotal_i > ref_vtotal_q) ? (vtotal_i - ref_vtotal_q)
                                             : (ref_vtotal_q - vtotal_i);
    assign match = (vdiff <= TOL) && (interlace_i == ref_il_q);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef SYNC_CTRL_WDOG_EN
    localparam logic [21:0] WDOG_LAST = 22'(WDOG_CYCLES);

    logic [21:0] wdog_cnt_q, wdog_cnt_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (fc_edge || (state_q == ST_UNLOCKED)) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_LAST) begin
            wdog_cnt_d = wdog_cnt_q + 22'd1;
        end
    end

    // A frame edge in the same cycle does not rescue the frontend: the
    // timeout has already elapsed.
    assign wdog_hit = (wdog_cnt_q == WDOG_LAST) && (state_q != ST_UNLOCKED);

    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    // Set wins over a simultaneous clearing write so a timeout is never lost.
    always_comb begin
        wdog_timeout_d = wdog_timeout_q;
        if (cfg_wr_i) begin
            wdog_timeout_d = 1'b0;
        end
        if (wdog_hit) begin
            wdog_timeout_d = 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;

    always_comb begin
        wdog_timeout_d = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ref_vtotal_d = ref_vtotal_q;
        ref_il_d     = ref_il_q;
        match_ctr_d  = match_ctr_q;
        miss_ctr_d   = miss_ctr_q;

        if (wdog_hit) begin
            state_d     = ST_UNLOCKED;
            match_ctr_d = '0;
            miss_ctr_d  = '0;
        end else if (fc_edge) begin
            case (state_q)
                ST_UNLOCKED: begin
                    ref_vtotal_d = vtotal_i;
                    ref_il_d     = interlace_i;
                    match_ctr_d  = '0;
                    state_d      = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        if (match_ctr_q == LOCK_LAST) begin
                            state_d     = ST_LOCKED;
                            match_ctr_d = '0;
                            miss_ctr_d  = '0;
                        end else begin
                            match_ctr_d = match_ctr_q + 8'd1;
                        end
                    end else begin
                        // Input changed mode mid-acquire: restart on the new timing.
                        ref_vtotal_d = vtotal_i;
                        ref_il_d     = interlace_i;
                        match_ctr_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        miss_ctr_d = '0;
                    end else if (miss_ctr_q == MISS_LAST) begin
                        state_d     = ST_UNLOCKED;
                        match_ctr_d = '0;
                        miss_ctr_d  = '0;
                    end else begin
                        miss_ctr_d = miss_ctr_q + 8'd1;
                    end
                end
                default: begin
                    state_d     = ST_UNLOCKED;
                    match_ctr_d = '0;
                    miss_ctr_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        sync_locked_d = (state_d == ST_LOCKED);
        mode_irq_d    = (state_d == ST_LOCKED) != (state_q == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Config shadow / apply
    // ------------------------------------------------------------------
    // A write in the apply cycle suppresses the apply so the fresh data is
    // never shadowed by the stale copy; it goes out at the next opportunity.
    assign apply_en = pending_q && !cfg_wr_i && ((state_q != ST_LOCKED) || fc_edge);

    always_comb begin
        shadow_h_d    = shadow_h_q;
        shadow_h2_d   = shadow_h2_q;
        shadow_v_d    = shadow_v_q;
        pending_d     = pending_q;
        active_h_d    = active_h_q;
        active_h2_d   = active_h2_q;
        active_v_d    = active_v_q;
        cfg_applied_d = 1'b0;

        if (cfg_wr_i) begin
            shadow_h_d  = cfg_h_i;
            shadow_h2_d = cfg_h2_i;
            shadow_v_d  = cfg_v_i;
            pending_d   = 1'b1;
        end else if (apply_en) begin
            active_h_d    = shadow_h_q;
            active_h2_d   = shadow_h2_q;
            active_v_d    = shadow_v_q;
            pending_d     = 1'b0;
            cfg_applied_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            fc_prev_q      <= 1'b0;
            state_q        <= ST_UNLOCKED;
            ref_vtotal_q   <= '0;
            ref_il_q       <= 1'b0;
            match_ctr_q    <= '0;
            miss_ctr_q     <= '0;
            sync_locked_q  <= 1'b0;
            mode_irq_q     <= 1'b0;
            shadow_h_q     <= '0;
            shadow_h2_q    <= '0;
            shadow_v_q     <= '0;
            pending_q      <= 1'b0;
            active_h_q     <= '0;
            active_h2_q    <= '0;
            active_v_q     <= '0;
            cfg_applied_q  <= 1'b0;
            wdog_timeout_q <= 1'b0;
        end else begin
            fc_prev_q      <= frame_change_i;
            state_q        <= state_d;
            ref_vtotal_q   <= ref_vtotal_d;
            ref_il_q       <= ref_il_d;
            match_ctr_q    <= match_ctr_d;
            miss_ctr_q     <= miss_ctr_d;
            sync_locked_q  <= sync_locked_d;
            mode_irq_q     <= mode_irq_d;
            shadow_h_q     <= shadow_h_d;
            shadow_h2_q    <= shadow_h2_d;
            shadow_v_q     <= shadow_v_d;
            pending_q      <= pending_d;
            active_h_q     <= active_h_d;
            active_h2_q    <= active_h2_d;
            active_v_q     <= active_v_d;
            cfg_applied_q  <= cfg_applied_d;
            wdog_timeout_q <= wdog_timeout_d;
        end
    end

    assign h_in_config_o   = active_h_q;
    assign h_in_config2_o  = active_h2_q;
    assign v_in_config_o   = active_v_q;
    assign cfg_applied_o   = cfg_applied_q;
    assign sync_locked_o   = sync_locked_q;
    assign locked_vtotal_o = ref_vtotal_q;
    assign locked_il_o     = ref_il_q;
    assign mode_irq_o      = mode_irq_q;
    assign wdog_timeout_o  = wdog_timeout_q;

endmodule
